// File: rtl/scene_rec_pkg.sv
// Shared types, constants and helpers for the dehaze scene-recovery scheduler.
package scene_rec_pkg;

  localparam int unsigned PIX_W     = 8;
  localparam int unsigned DIV_W_DEF = 16;
  localparam int unsigned T_MIN_DEF = 26;
  // Signed width for A +/- q; wide enough for 255 + 65280 and 0 - 65280.
  localparam int unsigned J_W       = DIV_W_DEF + 1;

  typedef enum logic [2:0] {
    StIdle,
    StChR,
    StChG,
    StChB,
    StOut
  } sched_state_e;

  typedef struct packed {
    logic [PIX_W-1:0] val;
    logic             sat;
  } sat_pix_t;

  // Clamp a signed J_W-bit value to [0,255] and report whether clamping happened.
  function automatic sat_pix_t sat_pix(input logic [J_W-1:0] v);
    sat_pix_t r;
    if (v[J_W-1]) begin
      r.val = '0;
      r.sat = 1'b1;
    end else if (|v[J_W-2:PIX_W]) begin
      r.val = '1;
      r.sat = 1'b1;
    end else begin
      r.val = v[PIX_W-1:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle. div_done pulses for one cycle
// DIV_W cycles after div_start; the quotient stays valid until the next div_start.
module seq_divider
  import scene_rec_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             div_start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [PIX_W-1:0] divisor,
  output logic [DIV_W-1:0] quotient,
  output logic             div_done
);

  logic [PIX_W:0]   rem_q, rem_n, rem_src;
  logic [DIV_W-1:0] quo_q, quo_n, quo_src;
  logic [4:0]       cnt_q, cnt_n;
  logic             run_q;
  logic             done_q;
  logic [PIX_W+1:0] shifted;

  // One restoring step; the first step is folded into the start cycle so the
  // last quotient bit lands exactly DIV_W cycles after div_start.
  always_comb begin
    rem_src = div_start ? '0 : rem_q;
    quo_src = div_start ? dividend : quo_q;
    shifted = {rem_src, quo_src[DIV_W-1]};
    if (shifted >= {2'b00, divisor}) begin
      rem_n = (PIX_W+1)'(shifted - {2'b00, divisor});
      quo_n = {quo_src[DIV_W-2:0], 1'b1};
    end else begin
      rem_n = shifted[PIX_W:0];
      quo_n = {quo_src[DIV_W-2:0], 1'b0};
    end
    cnt_n = div_start ? 5'd1 : cnt_q + 5'd1;
  end

  // Iteration registers, step counter and done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (div_start || run_q) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        cnt_q <= cnt_n;
        if (cnt_n == 5'(DIV_W)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end else begin
          run_q  <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q;
  assign div_done = done_q;

endmodule

// File: rtl/scene_recovery_sched.sv
// Dehaze recovery scheduler: J = A + (I-A)/t per channel, R then G then B, through one
// shared sequential divider. Optional macro SCENE_REC_TMIN_CLAMP_EN floors t at T_MIN;
// without it only t==0 is patched to 1.
module scene_recovery_sched
  import scene_rec_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
`ifdef SCENE_REC_TMIN_CLAMP_EN
  ,
  parameter int unsigned T_MIN = T_MIN_DEF
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             a_load,
  input  logic [PIX_W-1:0] a_r,
  input  logic [PIX_W-1:0] a_g,
  input  logic [PIX_W-1:0] a_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_r,
  input  logic [PIX_W-1:0] in_g,
  input  logic [PIX_W-1:0] in_b,
  input  logic [PIX_W-1:0] in_t,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_r,
  output logic [PIX_W-1:0] out_g,
  output logic [PIX_W-1:0] out_b,
  output logic [2:0]       sat_flags,
  output logic             busy
);

  sched_state_e state_q, state_d;
  logic         ch_first_q, ch_first_d;

  logic [2:0][PIX_W-1:0] a_sh_q;
  logic [2:0][PIX_W-1:0] pix_q;
  logic [2:0][PIX_W-1:0] a_w_q;
  logic [PIX_W-1:0]      t_q, t_lat;
  logic [2:0][PIX_W-1:0] res_q;
  logic [2:0]            sat_q;

  logic [1:0]       ch;
  logic             ch_active;
  logic [PIX_W-1:0] i_cur, a_cur, diff;
  logic             i_gt;
  logic [DIV_W-1:0] dividend, div_q;
  logic             div_start, div_done;
  logic [J_W-1:0]   a_ext, q_ext, j_wide;
  sat_pix_t         sat_res;
  logic             accept;

  // Divisor seen by the divider must never be zero.
  always_comb begin
`ifdef SCENE_REC_TMIN_CLAMP_EN
    t_lat = (in_t < PIX_W'(T_MIN)) ? PIX_W'(T_MIN) : in_t;
`else
    t_lat = (in_t == '0) ? PIX_W'(1) : in_t;
`endif
  end

  // Channel select and per-channel signed recovery arithmetic.
  always_comb begin
    ch        = 2'd0;
    ch_active = 1'b1;
    unique case (state_q)
      StChR:   ch = 2'd0;
      StChG:   ch = 2'd1;
      StChB:   ch = 2'd2;
      default: ch_active = 1'b0;
    endcase
    i_cur    = pix_q[ch];
    a_cur    = a_w_q[ch];
    i_gt     = i_cur > a_cur;
    diff     = i_gt ? (i_cur - a_cur) : (a_cur - i_cur);
    dividend = DIV_W'({diff, 8'h00});
    a_ext    = J_W'(a_cur);
    q_ext    = J_W'(div_q);
    j_wide   = i_gt ? (a_ext + q_ext) : (a_ext - q_ext);
    sat_res  = sat_pix(j_wide);
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    ch_first_d = 1'b0;
    in_ready   = (state_q == StIdle) && !reset;
    out_valid  = (state_q == StOut);
    busy       = (state_q != StIdle);
    div_start  = ch_active && ch_first_q;
    accept     = in_valid && in_ready;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StChR;
          ch_first_d = 1'b1;
        end
      end
      StChR: begin
        if (div_done) begin
          state_d    = StChG;
          ch_first_d = 1'b1;
        end
      end
      StChG: begin
        if (div_done) begin
          state_d    = StChB;
          ch_first_d = 1'b1;
        end
      end
      StChB: begin
        if (div_done) state_d = StOut;
      end
      StOut: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      ch_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_first_q <= ch_first_d;
    end
  end

  // A shadow, working copies latched at accept, and per-channel results.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_sh_q <= '0;
      pix_q  <= '0;
      a_w_q  <= '0;
      t_q    <= '0;
      res_q  <= '0;
      sat_q  <= '0;
    end else begin
      if (a_load) a_sh_q <= {a_b, a_g, a_r};
      // The shadow value before this edge is used, so a same-cycle a_load waits a pixel.
      if (accept) begin
        pix_q <= {in_b, in_g, in_r};
        a_w_q <= a_sh_q;
        t_q   <= t_lat;
      end
      if (ch_active && div_done) begin
        res_q[ch] <= sat_res.val;
        sat_q[ch] <= sat_res.sat;
      end
    end
  end

  seq_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clock     (clock),
    .reset     (reset),
    .div_start (div_start),
    .dividend  (dividend),
    .divisor   (t_q),
    .quotient  (div_q),
    .div_done  (div_done)
  );

  assign out_r     = res_q[0];
  assign out_g     = res_q[1];
  assign out_b     = res_q[2];
  assign sat_flags = sat_q;

endmodule

// File: tb/tb_scene_recovery_sched.sv
// Directed bench for scene_recovery_sched with hand-computed pixels.
module tb_scene_recovery_sched;

  logic       clock = 1'b0;
  logic       reset;
  logic       a_load;
  logic [7:0] a_r, a_g, a_b;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_r, in_g, in_b, in_t;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_r, out_g, out_b;
  logic [2:0] sat_flags;
  logic       busy;

  int n_chk = 0;
  int n_bad = 0;
  int lat;
  int seen;

  always #5 clock = ~clock;

  scene_recovery_sched dut (
    .clock     (clock),
    .reset     (reset),
    .a_load    (a_load),
    .a_r       (a_r),
    .a_g       (a_g),
    .a_b       (a_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_g      (in_g),
    .in_b      (in_b),
    .in_t      (in_t),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_g     (out_g),
    .out_b     (out_b),
    .sat_flags (sat_flags),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_a(input logic [7:0] v);
    a_r = v; a_g = v; a_b = v; a_load = 1'b1;
    step();
    a_load = 1'b0;
  endtask

  // Present one pixel and hold it until accepted (bounded).
  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic [7:0] t);
    int k;
    k = 0;
    while (!in_ready && k < 200) begin
      step();
      k++;
    end
    check_eq("in_ready_before_send", 32'(in_ready), 32'd1);
    in_r = r; in_g = g; in_b = b; in_t = t; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Cycles from the accept cycle to the first out_valid cycle.
  task automatic wait_out(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      step();
      cyc++;
    end
  endtask

  task automatic expect_pix(input string tag, input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b, input logic [2:0] s);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_r"}, 32'(out_r), 32'(r));
    check_eq({tag, "_g"}, 32'(out_g), 32'(g));
    check_eq({tag, "_b"}, 32'(out_b), 32'(b));
    check_eq({tag, "_sat"}, 32'(sat_flags), 32'(s));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; a_load = 1'b0; a_r = '0; a_g = '0; a_b = '0;
    in_valid = 1'b0; in_r = '0; in_g = '0; in_b = '0; in_t = '0; out_ready = 1'b0;
    repeat (3) step();
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_out", 32'({out_r, out_g, out_b, 5'd0, sat_flags}), 32'd0);
    reset = 1'b0;
    #1;
    check_eq("rst_release_ready", 32'(in_ready), 32'd1);

    // 1: plain darkening, latency 52.
    load_a(8'd200);
    send(8'd150, 8'd150, 8'd150, 8'd128);
    check_eq("t1_busy", 32'(busy), 32'd1);
    check_eq("t1_in_ready_busy", 32'(in_ready), 32'd0);
    wait_out(lat);
    check_eq("t1_latency", 32'(lat), 32'd52);
    expect_pix("t1", 8'd100, 8'd100, 8'd100, 3'b000);
    release_out("t1");

    // 2: high and low saturation.
    send(8'd220, 8'd100, 8'd200, 8'd64);
    wait_out(lat);
    expect_pix("t2", 8'd255, 8'd0, 8'd200, 3'b011);
    release_out("t2");

    // 3: t = 0.
    send(8'd201, 8'd200, 8'd200, 8'd0);
    wait_out(lat);
`ifdef SCENE_REC_TMIN_CLAMP_EN
    expect_pix("t3", 8'd209, 8'd200, 8'd200, 3'b000);
`else
    expect_pix("t3", 8'd255, 8'd200, 8'd200, 3'b001);
`endif
    release_out("t3");

    // 4: I == A, then a mid-pixel A change, then a_load together with accept.
    load_a(8'd77);
    send(8'd77, 8'd77, 8'd77, 8'd5);
    repeat (5) step();
    load_a(8'd10);
    wait_out(lat);
    expect_pix("t4a", 8'd77, 8'd77, 8'd77, 3'b000);
    release_out("t4a");
    a_r = 8'd50; a_g = 8'd50; a_b = 8'd50; a_load = 1'b1;
    send(8'd20, 8'd20, 8'd20, 8'd128);
    a_load = 1'b0;
    wait_out(lat);
    expect_pix("t4b", 8'd30, 8'd30, 8'd30, 3'b000);
    release_out("t4b");

    // 5: back-pressure in OUT with A = 50.
    send(8'd60, 8'd40, 8'd50, 8'd200);
    wait_out(lat);
    expect_pix("t5", 8'd62, 8'd38, 8'd50, 3'b000);
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("t5_hold_valid", 32'(out_valid), 32'd1);
      check_eq("t5_hold_r", 32'(out_r), 32'd62);
      check_eq("t5_hold_ready", 32'(in_ready), 32'd0);
    end
    expect_pix("t5_end", 8'd62, 8'd38, 8'd50, 3'b000);
    release_out("t5");

    // 6: reset mid-pixel discards it and clears A.
    send(8'd100, 8'd100, 8'd100, 8'd128);
    repeat (19) step();
    reset = 1'b1;
    step();
    check_eq("t6_rst_out", 32'({out_r, out_g, out_b, 5'd0, sat_flags}), 32'd0);
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    check_eq("t6_rst_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    #1;
    check_eq("t6_ready_after", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (out_valid) seen++;
    end
    check_eq("t6_no_out_valid", 32'(seen), 32'd0);
    send(8'd30, 8'd0, 8'd255, 8'd128);
    wait_out(lat);
    check_eq("t6_latency", 32'(lat), 32'd52);
    expect_pix("t6", 8'd60, 8'd0, 8'd255, 3'b100);
    release_out("t6");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
